tt_openframe_mux: RTL and testbench
===================================

# tt_openframe_mux

Top-level chip wrapper for the shared-die multiplexer: maps the 44-pin GPIO frame onto a TinyTapeout-style user interface (ui_in, uo_out, uio, clk, reset_n), and a small control interface selects one of four built-in user projects. Sits directly under the padframe; all pad-mode configuration (gpio_dm*, gpio_oeb, gpio_inp_dis) is generated here.

## Interface
- No parameters. Project count fixed at 4, address counter 8 bits.
- clk  in  1  system/project clock. Integration also routes it to gpio pin 6; wrapper logic uses only this port.
- rst  in  1  asynchronous, active-high global reset.
- gpio_loopback_zero  in  44  constant 0 per pin; tie-off source, otherwise unused.
- gpio_loopback_one  in  44  constant 1 per pin; tie-off source, otherwise unused.
- gpio_in  in  44  pad input values; 0 when input buffer disabled.
- gpio_out  out  44  pad output values.
- gpio_oeb  out  44  active-low output enable.
- gpio_inp_dis  out  44  1 = input buffer disabled.
- gpio_dm2 / gpio_dm1 / gpio_dm0  out  44 each  pad drive mode.

## Operation
- Pin map:
  - 6: clk (input).
  - 7: reset_n (input).
  - 15:8: ui_in.
  - 23:16: uo_out.
  - 31:24: uio.
  - 32: ctrl_ena.
  - 34: ctrl_sel_inc.
  - 36: ctrl_sel_rst_n.
- Pad modes:
  - Input: dm=001, oeb=1, inp_dis=0.
  - Output: dm=110, oeb=0, inp_dis=0, gpio_out=value.
  - Unused (0-5, 33, 35, 37-43): dm=000, oeb=1, inp_dis=1, out=0.
- uio pins, per bit i: output mode when the selected project's uio_oe[i]=1, else input mode.
- Control inputs (pins 32, 34, 36) pass through 2-flop synchronizers on clk.
- Address counter sel_addr[7:0]:
  - Cleared to 0 while synced ctrl_sel_rst_n=0.
  - Otherwise +1 on each synced rising edge of ctrl_sel_inc.
  - Wraps 255→0.
  - sel_rst_n low has priority over a simultaneous inc edge.
- Enable: ena = synced ctrl_ena. Project k is active iff ena=1 and sel_addr==k.
- Project reset: proj_rst = rst | ~reset_n | ~active. Asynchronous assert, synchronous release via 2-flop synchronizer.
- Projects (uo_out, uio_out, uio_oe):
  - 0 passthrough: uo_out=ui_in, uio_oe=0x00.
  - 1 counter: 8-bit cnt, 0 in reset, +1 every clk. uo_out=cnt, uio_out=cnt, uio_oe=0xFF.
  - 2 adder: uo_out=ui_in+uio_in mod 256 (combinational), uio_oe=0x00.
  - 3 inverter: uio_out=~ui_in, uo_out=0xA5, uio_oe=0xFF.
- No project active (ena=0 or sel_addr≥4): uo_out=0, uio_oe=0x00 (all uio inputs).

## Timing
- Reset values:
  - rst=1 asynchronously clears sel_addr, the synchronizers and project state.
  - During reset: uo_out=0, uio all inputs, pad modes as listed above (mode outputs are constant, independent of reset).
- Control latency: pin change to effect = 2 clk (synchronizer). sel_addr updates on the 3rd rising edge after the inc pin rises.
- Output path: project outputs to gpio_out are combinational from ui_in/uio_in and registered project state.
- Project 1 count:
  - First increment on the 1st clk after proj_rst release (release itself takes 2 clk).
  - Wraps 255→0.
- Changing sel_addr or ena mid-operation resets the deselected project and zeroes its outputs combinationally. Its state is lost.

## Test plan
- Reset: rst=1 → gpio_out[23:16]=0, gpio_oeb[31:24]=0xFF, dm on pins 23:16 = 110, pin 40 inp_dis=1.
- Passthrough: sel_rst_n pulse low, ena=1, ui_in=0x3C, wait 4 clk → uo_out=0x3C, uio all input.
- Counter: 1 inc pulse (addr=1), ena=1, reset_n low then high → uo_out and uio_out count 0,1,2…; after 256 more clk the value is back to its start; gpio_oeb[31:24]=0.
- Adder: addr=2, ui_in=0xF0, uio_in=0x20 → uo_out=0x10.
- Inverter/select: addr=3, ui_in=0x0F → uio_out=0xF0, uo_out=0xA5. 1 more inc (addr=4) → uo_out=0. ena=0 → uo_out=0.
- Wrap: 256 inc pulses from 0 → addr=0, passthrough active.

Source files
------------

// File: rtl/tt_openframe_mux.sv
// tt_openframe_mux: chip wrapper that maps the 44-pin GPIO frame onto a
// TinyTapeout-style user interface and selects one of four built-in projects.
// Pin map: 6 clk, 7 reset_n, 15:8 ui_in, 23:16 uo_out, 31:24 uio,
// 32 ctrl_ena, 34 ctrl_sel_inc, 36 ctrl_sel_rst_n. All other pins are unused.
module tt_openframe_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic [43:0] gpio_loopback_zero,
  input  logic [43:0] gpio_loopback_one,
  input  logic [43:0] gpio_in,
  output logic [43:0] gpio_out,
  output logic [43:0] gpio_oeb,
  output logic [43:0] gpio_inp_dis,
  output logic [43:0] gpio_dm2,
  output logic [43:0] gpio_dm1,
  output logic [43:0] gpio_dm0
);

  // Static pad classes: control/user inputs, dedicated outputs, bidir uio.
  localparam logic [43:0] in_mask  = 44'h015_0000_FFC0;
  localparam logic [43:0] out_mask = 44'h000_00FF_0000;
  localparam logic [43:0] uio_mask = 44'h000_FF00_0000;

  // User-side view of the frame.
  logic       reset_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign reset_n = gpio_in[7];
  assign ui_in   = gpio_in[15:8];
  assign uio_in  = gpio_in[31:24];

  // Pins the wrapper never reads (clk arrives on its own port; loopbacks are
  // tie-off sources only) are gathered here so their non-use is explicit.
  logic unused_pins;
  assign unused_pins = ^{gpio_loopback_zero, gpio_loopback_one,
                         gpio_in[43:37], gpio_in[35], gpio_in[33], gpio_in[6:0]};

  // Control synchronizers, inc edge detector and project address counter.
  logic [1:0] ena_sync;
  logic [1:0] inc_sync;
  logic [1:0] srn_sync;
  logic       inc_prev;
  logic [7:0] sel_addr;
  logic       inc_rise;

  assign inc_rise = inc_sync[1] & ~inc_prev;

  // Two-flop synchronizers feed the counter; a synced sel_rst_n low wins over an inc edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_sync <= 2'b00;
      inc_sync <= 2'b00;
      srn_sync <= 2'b00;
      inc_prev <= 1'b0;
      sel_addr <= 8'd0;
    end else begin
      ena_sync <= {ena_sync[0], gpio_in[32]};
      inc_sync <= {inc_sync[0], gpio_in[34]};
      srn_sync <= {srn_sync[0], gpio_in[36]};
      inc_prev <= inc_sync[1];
      if (!srn_sync[1]) begin
        sel_addr <= 8'd0;
      end else if (inc_rise) begin
        sel_addr <= sel_addr + 8'd1;
      end
    end
  end

  logic       ena;
  logic [3:0] proj_active;

  assign ena = ena_sync[1];
  assign proj_active[0] = ena & (sel_addr == 8'd0);
  assign proj_active[1] = ena & (sel_addr == 8'd1);
  assign proj_active[2] = ena & (sel_addr == 8'd2);
  assign proj_active[3] = ena & (sel_addr == 8'd3);

  // Project 1 is the only stateful project. Its reset asserts asynchronously
  // (global reset, user reset_n, or deselection) and releases after two clocks.
  logic       proj1_rst_a;
  logic [1:0] proj1_rst_sync;
  logic [7:0] cnt;

  assign proj1_rst_a = rst | ~reset_n | ~proj_active[1];

  // Reset release synchronizer for project 1.
  always_ff @(posedge clk or posedge proj1_rst_a) begin
    if (proj1_rst_a) begin
      proj1_rst_sync <= 2'b00;
    end else begin
      proj1_rst_sync <= {proj1_rst_sync[0], 1'b1};
    end
  end

  // Free-running 8-bit counter once the release has propagated.
  always_ff @(posedge clk or posedge proj1_rst_a) begin
    if (proj1_rst_a) begin
      cnt <= 8'd0;
    end else if (proj1_rst_sync[1]) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Project output mux; nothing selected leaves uo_out low and uio as inputs.
  always_comb begin
    uo_out  = 8'h00;
    uio_out = 8'h00;
    uio_oe  = 8'h00;
    if (proj_active[0]) begin
      uo_out = ui_in;
    end else if (proj_active[1]) begin
      uo_out  = cnt;
      uio_out = cnt;
      uio_oe  = 8'hFF;
    end else if (proj_active[2]) begin
      uo_out = ui_in + uio_in;
    end else if (proj_active[3]) begin
      uo_out  = 8'hA5;
      uio_out = ~ui_in;
      uio_oe  = 8'hFF;
    end
  end

  // Pad configuration: outputs dm=110, inputs dm=001, unused dm=000 and
  // input buffer disabled. uio pins follow the selected project's uio_oe.
  logic [43:0] uio_oe_pins;
  assign uio_oe_pins = {12'h000, uio_oe, 24'h000000};

  assign gpio_out     = {12'h000, uio_out & uio_oe, uo_out, 16'h0000};
  assign gpio_oeb     = ~(out_mask | uio_oe_pins);
  assign gpio_inp_dis = ~(in_mask | out_mask | uio_mask);
  assign gpio_dm2     = out_mask | uio_oe_pins;
  assign gpio_dm1     = out_mask | uio_oe_pins;
  assign gpio_dm0     = in_mask | (uio_mask & ~uio_oe_pins);

endmodule

// File: tb/tb_tt_openframe_mux.sv
// Testbench for tt_openframe_mux: directed scenarios plus randomized control
// and data traffic, checked every cycle against a behavioural model.
module tb_tt_openframe_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [43:0] lb_zero = '0;
  logic [43:0] lb_one  = '1;
  logic [43:0] gpio_in = '0;
  logic [43:0] gpio_out, gpio_oeb, gpio_inp_dis, gpio_dm2, gpio_dm1, gpio_dm0;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  tt_openframe_mux dut (
    .clk                (clk),
    .rst                (rst),
    .gpio_loopback_zero (lb_zero),
    .gpio_loopback_one  (lb_one),
    .gpio_in            (gpio_in),
    .gpio_out           (gpio_out),
    .gpio_oeb           (gpio_oeb),
    .gpio_inp_dis       (gpio_inp_dis),
    .gpio_dm2           (gpio_dm2),
    .gpio_dm1           (gpio_dm1),
    .gpio_dm0           (gpio_dm0)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Control pins reach the design two clocks late; an inc edge acts one
  // clock after that. Pin history: x1 = sample one edge ago, x2 two, x3 three.
  int m_addr = 0;
  bit m_ena = 0;
  bit e1 = 0, s1 = 0, s2 = 0, i1 = 0, i2 = 0, i3 = 0;
  int age = 0;      // edges since project 1 was last held in reset
  bit cond_before;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr = 0; m_ena = 0; age = 0;
      e1 = 0; s1 = 0; s2 = 0; i1 = 0; i2 = 0; i3 = 0;
    end else begin
      cond_before = !gpio_in[7] || !(m_ena && m_addr == 1);
      m_ena = e1;
      if (!s2) m_addr = 0;
      else if (i2 && !i3) m_addr = (m_addr + 1) % 256;
      i3 = i2; i2 = i1; i1 = gpio_in[34];
      s2 = s1; s1 = gpio_in[36];
      e1 = gpio_in[32];
      age = cond_before ? 0 : age + 1;
      if (!(m_ena && m_addr == 1)) age = 0;
      if (age > 1000) age = age - 256;
    end
  end

  function automatic void exp_pads(input logic [7:0] uo, input logic [7:0] uo_io,
                                   input logic [7:0] oe,
                                   output logic [43:0] o, output logic [43:0] oeb,
                                   output logic [43:0] idis, output logic [43:0] d2,
                                   output logic [43:0] d1, output logic [43:0] d0);
    for (int p = 0; p < 44; p++) begin
      // default: unused pin
      o[p] = 0; oeb[p] = 1; idis[p] = 1; d2[p] = 0; d1[p] = 0; d0[p] = 0;
      if ((p >= 6 && p <= 15) || p == 32 || p == 34 || p == 36) begin
        idis[p] = 0; d0[p] = 1;
      end else if (p >= 16 && p <= 23) begin
        o[p] = uo[p-16]; oeb[p] = 0; idis[p] = 0; d2[p] = 1; d1[p] = 1;
      end else if (p >= 24 && p <= 31) begin
        idis[p] = 0;
        if (oe[p-24]) begin
          o[p] = uo_io[p-24]; oeb[p] = 0; d2[p] = 1; d1[p] = 1;
        end else begin
          d0[p] = 1;
        end
      end
    end
  endfunction

  logic [7:0]  e_uo, e_uio, e_oe, e_cnt, ui_v, uio_v;
  logic [43:0] x_o, x_oeb, x_idis, x_d2, x_d1, x_d0;
  bit          cond_now;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      ui_v  = gpio_in[15:8];
      uio_v = gpio_in[31:24];
      cond_now = rst || !gpio_in[7] || !(m_ena && m_addr == 1);
      e_cnt = cond_now ? 8'd0 : (age >= 2 ? 8'((age - 2) % 256) : 8'd0);
      e_uo = 8'h00; e_uio = 8'h00; e_oe = 8'h00;
      if (m_ena && m_addr < 4) begin
        case (m_addr)
          0: e_uo = ui_v;
          1: begin e_uo = e_cnt; e_uio = e_cnt; e_oe = 8'hFF; end
          2: e_uo = 8'((int'(ui_v) + int'(uio_v)) % 256);
          default: begin e_uo = 8'hA5; e_uio = ~ui_v; e_oe = 8'hFF; end
        endcase
      end
      exp_pads(e_uo, e_uio, e_oe, x_o, x_oeb, x_idis, x_d2, x_d1, x_d0);
      check("gpio_out", gpio_out, x_o);
      check("gpio_oeb", gpio_oeb, x_oeb);
      check("gpio_inp_dis", gpio_inp_dis, x_idis);
      check("gpio_dm2", gpio_dm2, x_d2);
      check("gpio_dm1", gpio_dm1, x_d1);
      check("gpio_dm0", gpio_dm0, x_d0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic inc_pulse();
    gpio_in[34] = 1'b1;
    tick(2);
    gpio_in[34] = 1'b0;
    tick(2);
  endtask

  task automatic sel_rst_pulse();
    gpio_in[36] = 1'b0;
    tick(3);
    gpio_in[36] = 1'b1;
    tick(1);
  endtask

  logic [7:0] v0;

  initial begin
    gpio_in[7]  = 1'b1;   // reset_n high
    gpio_in[36] = 1'b1;   // sel_rst_n high
    #1 rst = 1'b1;
    check_en = 1'b1;
    tick(3);
    // Reset state
    check("rst_uo", 44'(gpio_out[23:16]), 44'h00);
    check("rst_uio_oeb", 44'(gpio_oeb[31:24]), 44'hFF);
    check("rst_dm_uo", 44'({gpio_dm2[23:16], gpio_dm1[23:16], gpio_dm0[23:16]}), 44'hFFFF00);
    check("rst_pin40_inp_dis", 44'(gpio_inp_dis[40]), 44'h1);
    rst = 1'b0;
    tick(2);

    // Passthrough
    gpio_in[32] = 1'b1;
    gpio_in[15:8] = 8'h3C;
    sel_rst_pulse();
    tick(4);
    check("pass_uo", 44'(gpio_out[23:16]), 44'h3C);
    check("pass_uio_oeb", 44'(gpio_oeb[31:24]), 44'hFF);

    // Counter
    inc_pulse();
    tick(2);
    gpio_in[7] = 1'b0;
    tick(3);
    check("cnt_in_reset", 44'(gpio_out[23:16]), 44'h00);
    gpio_in[7] = 1'b1;
    tick(3);
    check("cnt_first_uo", 44'(gpio_out[23:16]), 44'h01);
    check("cnt_first_uio", 44'(gpio_out[31:24]), 44'h01);
    check("cnt_uio_oeb", 44'(gpio_oeb[31:24]), 44'h00);
    tick(1);
    check("cnt_second", 44'(gpio_out[23:16]), 44'h02);
    v0 = gpio_out[23:16];
    tick(256);
    check("cnt_wrap_256", 44'(gpio_out[23:16]), 44'(v0));

    // Adder
    inc_pulse();
    tick(2);
    gpio_in[15:8]  = 8'hF0;
    gpio_in[31:24] = 8'h20;
    tick(1);
    check("add_uo", 44'(gpio_out[23:16]), 44'h10);

    // Inverter
    inc_pulse();
    tick(2);
    gpio_in[15:8] = 8'h0F;
    tick(1);
    check("inv_uio", 44'(gpio_out[31:24]), 44'hF0);
    check("inv_uo", 44'(gpio_out[23:16]), 44'hA5);

    // Address 4: nothing selected
    inc_pulse();
    tick(2);
    check("addr4_uo", 44'(gpio_out[23:16]), 44'h00);

    // Back to passthrough, then disable
    sel_rst_pulse();
    tick(3);
    check("pass_again_uo", 44'(gpio_out[23:16]), 44'h0F);
    gpio_in[32] = 1'b0;
    tick(4);
    check("ena0_uo", 44'(gpio_out[23:16]), 44'h00);

    // Wrap: 256 inc pulses from 0
    gpio_in[32] = 1'b1;
    sel_rst_pulse();
    for (int k = 0; k < 256; k++) inc_pulse();
    tick(4);
    gpio_in[15:8] = 8'h5A;
    tick(1);
    check("wrap_uo", 44'(gpio_out[23:16]), 44'h5A);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      gpio_in[15:8]  = 8'($urandom);
      gpio_in[31:24] = 8'($urandom);
      if ($urandom_range(0, 49) == 0) gpio_in[32] = ~gpio_in[32];
      if ($urandom_range(0, 2) == 0) gpio_in[34] = ~gpio_in[34];
      gpio_in[36] = ($urandom_range(0, 79) != 0);
      gpio_in[7]  = ($urandom_range(0, 119) != 0);
      if (c == 1500) rst = 1'b1;
      if (c == 1502) rst = 1'b0;
      tick(1);
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
